// File: rtl/alu_4_seq_pkg.sv
// Shared types and sizes for the alu_4 sweep engine (alu_4_seq).
package alu_4_seq_pkg;
    localparam int NUM_OPS = 16;
    localparam int DATA_W  = 4;
    localparam int OP_W    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_t;
endpackage

// File: rtl/alu_4_seq_rbuf.sv
// 16-entry result buffer with per-opcode timeout flags and a registered read port.
module alu_4_seq_rbuf
    import alu_4_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_err,
    input  logic                we,
    input  logic [OP_W-1:0]     waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                werr,
    input  logic [OP_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic [NUM_OPS-1:0]  err_mask
);

    logic [DATA_W-1:0] mem [NUM_OPS];

    // The read samples the array before this edge's write lands, so a
    // same-address read/write returns the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OPS; i++) mem[i] <= '0;
            rd_data  <= '0;
            err_mask <= '0;
        end else begin
            rd_data <= mem[rd_addr];
            if (clr_err) err_mask <= '0;
            if (we) begin
                mem[waddr] <= wdata;
                if (werr) err_mask[waddr] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_4_seq.sv
// Opcode sweep engine for alu_4: drives a/b/s, captures res on ack, flags timeouts.
// Optional checksum output enabled by defining ALU4_SEQ_CHECKSUM_EN.
module alu_4_seq
    import alu_4_seq_pkg::*;
#(
    parameter int HOLD_CYC = 2,
    parameter int TIMEOUT  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   a,
    output logic [DATA_W-1:0]   b,
    output logic [OP_W-1:0]     s,
    input  logic [DATA_W-1:0]   res,
    input  logic                ack,
    input  logic [OP_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic [NUM_OPS-1:0]  err_mask
`ifdef ALU4_SEQ_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]   checksum
`endif
);

    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [OP_W-1:0] OP_LAST   = OP_W'(NUM_OPS - 1);

    state_t            state;
    logic [HW-1:0]     hold_cnt;
    logic [TW-1:0]     to_cnt;
    logic              accept;
    logic              wr_en;
    logic              wr_err;
    logic [DATA_W-1:0] wr_data;

    // A capture in the last WAIT cycle takes priority over the timeout.
    always_comb begin
        accept  = (state == S_IDLE) && start;
        wr_en   = (state == S_WAIT) && (ack || (to_cnt == TO_LAST));
        wr_err  = !ack;
        wr_data = ack ? res : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            to_cnt   <= '0;
            a        <= '0;
            b        <= '0;
            s        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a        <= op_a;
                        b        <= op_b;
                        s        <= '0;
                        hold_cnt <= '0;
                        to_cnt   <= '0;
                        busy     <= 1'b1;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (hold_cnt == HOLD_LAST) state <= S_WAIT;
                    else                       hold_cnt <= hold_cnt + HW'(1);
                end
                S_WAIT: begin
                    if (wr_en) state  <= S_STORE;
                    else       to_cnt <= to_cnt + TW'(1);
                end
                S_STORE: begin
                    hold_cnt <= '0;
                    to_cnt   <= '0;
                    if (s == OP_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        s     <= s + OP_W'(1);
                        state <= S_SETUP;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU4_SEQ_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst)        checksum <= '0;
        else if (accept) checksum <= '0;
        else if (wr_en)  checksum <= checksum ^ wr_data;
    end
`endif

    alu_4_seq_rbuf u_rbuf (
        .clk      (clk),
        .rst      (rst),
        .clr_err  (accept),
        .we       (wr_en),
        .waddr    (s),
        .wdata    (wr_data),
        .werr     (wr_err),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .err_mask (err_mask)
    );

endmodule
